// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the RISC-V instruction-fetch front end.
//   fetch_state_e  : fetch controller states
//   fetch_entry_t  : instruction + PC pair (held in the stall buffer)
//   fetch_out_t    : contents of the fetch/decode pipeline latch
//   PC_W, PC_INC, NOP_INSN, pc_inc()
package riscv_fetch_pkg;

  localparam int unsigned      PC_W     = 12;
  localparam logic [PC_W-1:0]  PC_INC   = 12'd4;
  localparam logic [31:0]      NOP_INSN = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request presented to instruction memory
    ST_WAIT = 2'd1,  // request accepted, response outstanding
    ST_HOLD = 2'd2,  // response captured while decode is stalled
    ST_DROP = 2'd3   // outstanding response belongs to a flushed path
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     insn;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0]     insn;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus;
    logic            valid;
  } fetch_out_t;

  // Sequential PC; 12-bit arithmetic wraps 12'hFFC -> 12'h000.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel.
//   req_valid / req_ready : request handshake, addr is the byte address
//   rsp_valid / rsp_data  : exactly one response per accepted request,
//                           at least one cycle after acceptance
// master : fetch side (drives requests, receives responses)
// slave  : memory side
interface fetch_unit_if;
  import riscv_fetch_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [PC_W-1:0] addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;

  modport master (
    output req_valid,
    output addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Keeps the PC, issues one outstanding request at a time to instruction
// memory and loads {insn, PC, PC+4, valid} into the fetch/decode latch.
// Decode stalls freeze the latch; a response arriving during a stall is
// parked in a one-entry buffer. Execute-stage redirects flush everything,
// restart at the target and discard any response still in flight.
//
// Ports
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   i_stall          : decode cannot accept; latch holds its value
//   i_redirect(_pc)  : flush and restart fetch at i_redirect_pc
//   imem             : instruction-memory channel (master side)
//   o_insn, o_PC     : instruction and its PC
//   o_PC_plus        : o_PC + 4 (mod 4096)
//   o_valid          : o_insn is a real instruction (else a NOP bubble)
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [PC_W-1:0]   i_redirect_pc,
  fetch_unit_if.master      imem,
  output logic [31:0]       o_insn,
  output logic [PC_W-1:0]   o_PC,
  output logic [PC_W-1:0]   o_PC_plus,
  output logic              o_valid
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  fetch_out_t      out_q, out_d;
  fetch_entry_t    buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;
  logic            req_fire;

  // Requests are presented only in REQ, so at most one is ever outstanding.
  assign imem.req_valid = (state_q == ST_REQ);
  assign imem.addr      = pc_q;
  assign req_fire       = imem.req_valid && imem.req_ready;

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;

    // With no load this cycle: a stalled decode keeps the latch as is,
    // otherwise it sees a bubble (PC fields left untouched).
    if (!i_stall) begin
      out_d.insn  = NOP_INSN;
      out_d.valid = 1'b0;
    end

    unique case (state_q)
      ST_REQ: begin
        if (req_fire) state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (imem.rsp_valid) begin
          pc_d = pc_inc(pc_q);
          if (!i_stall) begin
            out_d.insn    = imem.rsp_data;
            out_d.pc      = pc_q;
            out_d.pc_plus = pc_inc(pc_q);
            out_d.valid   = 1'b1;
            state_d       = ST_REQ;
          end else begin
            // Decode is busy: park the instruction, latch keeps its value.
            buf_d.insn  = imem.rsp_data;
            buf_d.pc    = pc_q;
            buf_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (!i_stall) begin
          out_d.insn    = buf_q.insn;
          out_d.pc      = buf_q.pc;
          out_d.pc_plus = pc_inc(buf_q.pc);
          out_d.valid   = 1'b1;
          buf_valid_d   = 1'b0;
          state_d       = ST_REQ;
        end
      end

      ST_DROP: begin
        // Response to a flushed request: swallow it, then fetch again.
        if (imem.rsp_valid) state_d = ST_REQ;
      end

      default: state_d = ST_REQ;
    endcase

    // Redirect overrides stall and any load in the same cycle.
    if (i_redirect) begin
      pc_d        = i_redirect_pc;
      out_d.insn  = NOP_INSN;
      out_d.valid = 1'b0;
      buf_valid_d = 1'b0;
      unique case (state_q)
        // A request accepted in this very cycle is now in flight.
        ST_REQ:           state_d = req_fire ? ST_DROP : ST_REQ;
        // An in-flight response is dropped unless it lands this cycle.
        ST_WAIT, ST_DROP: state_d = imem.rsp_valid ? ST_REQ : ST_DROP;
        ST_HOLD:          state_d = ST_REQ;
        default:          state_d = ST_REQ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC;
      out_q       <= '{insn: NOP_INSN, pc: '0, pc_plus: '0, valid: 1'b0};
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // NOTE: the buffer payload is qualified by buf_valid_q / ST_HOLD, so it
  // needs no reset and is kept out of the reset network.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign o_insn    = out_q.insn;
  assign o_PC      = out_q.pc;
  assign o_PC_plus = out_q.pc_plus;
  assign o_valid   = out_q.valid;

  // ---------------------------------------------------------------------
  // Protocol checks (simulation only)
  // ---------------------------------------------------------------------
`ifndef SYNTHESIS
  // Memory may only answer a request that is actually outstanding.
  a_rsp_only_when_outstanding : assert property (
    @(posedge clock) disable iff (reset)
    imem.rsp_valid |-> (state_q == ST_WAIT || state_q == ST_DROP)
  );

  // A valid instruction always carries a consistent PC+4.
  a_pc_plus_consistent : assert property (
    @(posedge clock) disable iff (reset)
    o_valid |-> (o_PC_plus == pc_inc(o_PC))
  );

  // The hold buffer is occupied exactly while in HOLD.
  a_buf_matches_state : assert property (
    @(posedge clock) disable iff (reset)
    buf_valid_q == (state_q == ST_HOLD)
  );
`endif

endmodule
